// File: rtl/db_event_arbiter.sv
// db_event_arbiter: debounces N raw push buttons and serialises their rising
// edges onto one valid/ready event port with round-robin arbitration.
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset
//   btn       raw asynchronous button inputs (N)
//   ev_ready  consumer accepts the presented event
//   db_level  debounced button levels (N), registered
//   pend      pending-event flags (N), registered
//   ev_valid  event available, registered
//   ev_id     index of the button whose event is presented (IDW), registered
//   overflow  sticky: an event arrived while its button was still pending
module db_event_arbiter #(
  parameter int unsigned N      = 4,
  parameter int unsigned IDW    = 2,
  parameter int unsigned TICK_N = 19,
  parameter int unsigned STABLE = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   btn,
  input  logic           ev_ready,
  output logic [N-1:0]   db_level,
  output logic [N-1:0]   pend,
  output logic           ev_valid,
  output logic [IDW-1:0] ev_id,
  output logic           overflow
);

  localparam int unsigned CW = 3;

  typedef enum logic {IDLE, GRANT} state_t;

  logic [N-1:0]      sync1;
  logic [N-1:0]      sync2;
  logic [TICK_N-1:0] tcnt;
  logic              tick;
  logic [CW-1:0]     cnt [N];
  logic [N-1:0]      db_level_d;
  logic [N-1:0]      rise;
  logic [N-1:0]      clr;
  logic [N-1:0]      pend_nxt;
  logic              ovf_hit;
  logic              found;
  logic [IDW-1:0]    sel;
  logic [IDW-1:0]    ptr;
  state_t            state;

  // Two-flop synchroniser on the raw pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Shared sample timer; tick fires once per wrap.
  always_ff @(posedge clk) begin
    if (reset) tcnt <= '0;
    else       tcnt <= tcnt + TICK_N'(1);
  end

  assign tick = &tcnt;

  // Per-button stability counter: the level flips only after STABLE
  // consecutive ticks that disagree with it; any agreeing tick restarts.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
      db_level <= '0;
    end else if (tick) begin
      for (int i = 0; i < N; i++) begin
        if (sync2[i] != db_level[i]) begin
          if (CW'(cnt[i] + CW'(1)) == CW'(STABLE)) begin
            db_level[i] <= ~db_level[i];
            cnt[i]      <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign rise = db_level & ~db_level_d;

  // A handshake frees the granted slot in the same edge a new rise may
  // refill it, so a rise coinciding with its own clear is not an overflow.
  always_comb begin
    clr = '0;
    if (state == GRANT && ev_ready) clr = N'(1) << ev_id;
    pend_nxt = (pend & ~clr) | rise;
    ovf_hit  = |(rise & pend & ~clr);
  end

  // Round-robin pick: first pending index at or above ptr, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && pend[IDW'((32'(ptr) + 32'(k)) % N)]) begin
        found = 1'b1;
        sel   = IDW'((32'(ptr) + 32'(k)) % N);
      end
    end
  end

  // Pending flags, sticky overflow and the IDLE/GRANT arbiter.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_level_d <= '0;
      pend       <= '0;
      overflow   <= 1'b0;
      ev_valid   <= 1'b0;
      ev_id      <= '0;
      ptr        <= '0;
      state      <= IDLE;
    end else begin
      db_level_d <= db_level;
      pend       <= pend_nxt;
      overflow   <= overflow | ovf_hit;
      case (state)
        IDLE: begin
          if (found) begin
            ev_id    <= sel;
            ev_valid <= 1'b1;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (ev_ready) begin
            ev_valid <= 1'b0;
            ptr      <= ev_id + IDW'(1);
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_db_event_arbiter.sv
// Bench for db_event_arbiter: a cycle-level reference model predicts levels,
// pending flags and every grant; grants go into a scoreboard queue that a
// separate monitor drains whenever the DUT presents a new event.
module tb_db_event_arbiter;

  localparam int unsigned N      = 4;
  localparam int unsigned IDW    = 2;
  localparam int unsigned TICK_N = 2;
  localparam int unsigned STABLE = 3;
  localparam int          TPER   = 1 << TICK_N;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   btn = '0;
  logic           ev_ready = 1'b0;
  logic [N-1:0]   db_level;
  logic [N-1:0]   pend;
  logic           ev_valid;
  logic [IDW-1:0] ev_id;
  logic           overflow;

  db_event_arbiter #(.N(N), .IDW(IDW), .TICK_N(TICK_N), .STABLE(STABLE)) dut (
    .clk(clk), .reset(reset), .btn(btn), .ev_ready(ev_ready),
    .db_level(db_level), .pend(pend), .ev_valid(ev_valid), .ev_id(ev_id),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_tcnt;
  bit m_s1[N], m_s2[N], m_lvl[N], m_lvl_d[N], m_pend[N];
  int m_cnt[N];
  bit m_valid, m_ovf, m_init;
  int m_id, m_ptr;
  int exp_q[$];
  int grant_log[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [N-1:0] pack(bit a[N]);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = a[i];
    return v;
  endfunction

  // One clock of the behavioural model, using values seen at the edge.
  task automatic model_step();
    bit rise[N];
    bit np[N];
    bit hs, keep, tick;
    if (reset) begin
      m_tcnt = 0; m_valid = 0; m_ovf = 0; m_id = 0; m_ptr = 0;
      for (int i = 0; i < N; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_lvl_d[i] = 0;
        m_pend[i] = 0; m_cnt[i] = 0;
      end
      exp_q.delete();
      m_init = 1;
      return;
    end
    hs = m_valid && ev_ready;
    for (int i = 0; i < N; i++) begin
      rise[i] = m_lvl[i] && !m_lvl_d[i];
      keep    = m_pend[i] && !(hs && m_id == i);
      np[i]   = keep || rise[i];
      if (rise[i] && keep) m_ovf = 1;
    end
    if (!m_valid) begin
      for (int k = 0; k < N; k++) begin
        int idx = (m_ptr + k) % N;
        if (!m_valid && m_pend[idx]) begin
          m_valid = 1;
          m_id    = idx;
          exp_q.push_back(idx);
        end
      end
    end else if (ev_ready) begin
      m_valid = 0;
      m_ptr   = (m_id + 1) % N;
    end
    tick = (m_tcnt % TPER) == TPER - 1;
    for (int i = 0; i < N; i++) begin
      m_lvl_d[i] = m_lvl[i];
      if (tick) begin
        if (m_s2[i] != m_lvl[i]) begin
          if (m_cnt[i] + 1 == STABLE) begin
            m_lvl[i] = !m_lvl[i];
            m_cnt[i] = 0;
          end else begin
            m_cnt[i]++;
          end
        end else begin
          m_cnt[i] = 0;
        end
      end
      m_s2[i]   = m_s1[i];
      m_s1[i]   = btn[i];
      m_pend[i] = np[i];
    end
    m_tcnt++;
  endtask

  initial begin
    m_init = 0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: per-cycle state comparison plus scoreboard pop on new events.
  initial begin
    bit prev_v;
    prev_v = 0;
    forever begin
      @(negedge clk);
      if (m_init) begin
        check("db_level", 32'(db_level), 32'(pack(m_lvl)));
        check("pend", 32'(pend), 32'(pack(m_pend)));
        check("ev_valid", 32'(ev_valid), 32'(m_valid));
        check("ev_id", 32'(ev_id), 32'(m_id));
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (ev_valid === 1'b1 && !prev_v) begin
          grant_log.push_back(int'(ev_id));
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_unexpected: got event id %0d expected none at %0t", ev_id, $time);
          end else begin
            check("sb_id", 32'(ev_id), 32'(exp_q.pop_front()));
          end
        end
        prev_v = (ev_valid === 1'b1);
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_log(string name, int exp[$]);
    check({name, "_count"}, 32'(grant_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < grant_log.size(); i++)
      check(name, 32'(grant_log[i]), 32'(exp[i]));
  endtask

  initial begin
    int none[$];
    // Reset with all buttons pressed
    reset = 1; btn = 4'hF;
    step(2);
    reset = 0; btn = '0;
    @(negedge clk);
    check("rst_db_level", 32'(db_level), 32'h0);
    check("rst_pend", 32'(pend), 32'h0);
    check("rst_ev_valid", 32'(ev_valid), 32'h0);
    check("rst_ev_id", 32'(ev_id), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    step(1);

    // Single press, always ready
    grant_log.delete();
    ev_ready = 1; btn = 4'b0001;
    step(30);
    btn = '0;
    step(30);
    check_log("single", '{0});

    // Bouncing button 1 never settles long enough
    grant_log.delete();
    for (int t = 0; t < 12; t++) begin
      btn[1] = ~btn[1];
      step(5);
    end
    btn = '0;
    step(30);
    check_log("bounce", none);
    check("bounce_overflow", 32'(overflow), 32'h0);

    // Simultaneous press from ptr=0
    reset = 1;
    step(1);
    reset = 0;
    grant_log.delete();
    btn = 4'hF;
    step(40);
    btn = '0;
    step(30);
    check_log("fair", '{0, 1, 2, 3});

    // Round-robin from ptr=3 with backpressure
    grant_log.delete();
    btn = 4'b0100;
    step(30);
    btn = '0;
    step(30);
    ev_ready = 0; btn = 4'b1001;
    step(40);
    ev_ready = 1;
    step(10);
    btn = '0;
    step(30);
    check_log("rr", '{2, 3, 0});

    // Overflow: second press while first still pending
    grant_log.delete();
    ev_ready = 0;
    btn = 4'b0001; step(25);
    btn = '0;      step(25);
    btn = 4'b0001; step(25);
    btn = '0;      step(20);
    check("ovf_set", 32'(overflow), 32'h1);
    check("ovf_pend", 32'(pend[0]), 32'h1);
    ev_ready = 1;
    step(10);
    check_log("ovf_deliver", '{0});

    // Reset while an event is presented
    ev_ready = 0; btn = 4'b0010;
    step(25);
    @(negedge clk);
    check("pre_rst_valid", 32'(ev_valid), 32'h1);
    step(1);
    reset = 1; btn = '0;
    step(1);
    reset = 0;
    @(negedge clk);
    check("midrst_valid", 32'(ev_valid), 32'h0);
    check("midrst_pend", 32'(pend), 32'h0);
    check("midrst_overflow", 32'(overflow), 32'h0);
    step(1);

    // Randomised traffic
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 11) == 0) btn[$urandom_range(0, N - 1)] ^= 1'b1;
      ev_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 999) == 0);
      step(1);
    end
    reset = 0; btn = '0; ev_ready = 1;
    step(60);
    check("sb_drain", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
